// File: rtl/sa_pkg.sv
// Shared definitions for the output-stationary systolic engine.
//   sa_state_e     : job FSM states (IDLE, LOAD, FLUSH, DRAIN).
//   sa_ext_product : multiplies two dw-bit operands after extending each to
//                    64 bits (sign- or zero-extension), so the low bits of the
//                    result are the correctly extended product.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } sa_state_e;

  // Operands arrive zero-padded in 64-bit containers; dw gives their real width.
  function automatic logic [63:0] sa_ext_product(
    input logic [63:0] a,
    input logic [63:0] b,
    input int unsigned dw,
    input logic        is_signed
  );
    logic [63:0] hi_mask;
    logic [63:0] sign_bit;
    logic [63:0] a_x;
    logic [63:0] b_x;
    hi_mask  = ~64'd0 << dw;
    sign_bit = 64'd1 << (dw - 32'd1);
    if (is_signed && ((a & sign_bit) != 64'd0)) begin
      a_x = a | hi_mask;
    end else begin
      a_x = a & ~hi_mask;
    end
    if (is_signed && ((b & sign_bit) != 64'd0)) begin
      b_x = b | hi_mask;
    end else begin
      b_x = b & ~hi_mask;
    end
    return a_x * b_x;
  endfunction

endpackage

// File: rtl/sa_os_pe.sv
// One output-stationary processing element.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_adv            : datapath advance; pass registers load and acc += a*b
//   i_clear_acc      : zero the accumulator (wins over i_adv)
//   i_a, i_b         : operand from the left / from above
//   o_a, o_b         : registered operand forwarded right / downward
//   o_acc            : running accumulator, wraps modulo 2^ACC_W
module sa_os_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter bit SIGNED = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_adv,
  input  logic              i_clear_acc,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [ACC_W-1:0]  o_acc
);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_prod;

  // Low ACC_W bits of the extended product; ACC_W >= 2*DATA_W keeps it exact.
  assign w_prod = ACC_W'(sa_ext_product(64'(i_a), 64'(i_b), DATA_W, SIGNED));

  // Operand pass registers and accumulator, all gated by the advance strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a   <= {DATA_W{1'b0}};
      r_b   <= {DATA_W{1'b0}};
      r_acc <= {ACC_W{1'b0}};
    end else begin
      if (i_adv) begin
        r_a <= i_a;
        r_b <= i_b;
      end
      if (i_clear_acc) begin
        r_acc <= {ACC_W{1'b0}};
      end else if (i_adv) begin
        r_acc <= r_acc + w_prod;
      end
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/sa_os_engine.sv
// Output-stationary systolic matrix-multiply engine: C = A * B.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_start, i_k_len      : job start (IDLE only) and inner dimension K
//   o_busy                : high outside IDLE
//   i_in_valid/o_in_ready : operand beat handshake (ready only in LOAD)
//   i_a_in, i_b_in        : column k of A (lane r -> PE row r), row k of B
//   o_out_valid/i_out_ready, o_out_data, o_out_row, o_out_last : result rows
//   o_done                : one-cycle pulse after the last row is accepted
module sa_os_engine
  import sa_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int NUM_ROW = 16,
  parameter int NUM_COL = 16,
  parameter int K_W     = 10,
  parameter bit SIGNED  = 1'b1,
  localparam int ROW_W  = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [K_W-1:0]           i_k_len,
  output logic                     o_busy,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [NUM_ROW*DATA_W-1:0] i_a_in,
  input  logic [NUM_COL*DATA_W-1:0] i_b_in,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [NUM_COL*ACC_W-1:0] o_out_data,
  output logic [ROW_W-1:0]         o_out_row,
  output logic                     o_out_last,
  output logic                     o_done
);

  localparam int FL_W = $clog2(NUM_ROW + NUM_COL);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(NUM_ROW + NUM_COL - 2);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROW - 1);
  localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
  localparam logic [K_W-1:0]   K_ONE      = K_W'(1);

  sa_state_e                r_state;
  logic [K_W-1:0]           r_k_len;
  logic [K_W-1:0]           r_beat_cnt;
  logic [FL_W-1:0]          r_flush_cnt;
  logic                     r_busy;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic                     r_done;
  logic [ROW_W-1:0]         r_out_row;
  logic [NUM_COL*ACC_W-1:0] r_out_data;
  logic [ACC_W-1:0]         r_bank [NUM_ROW][NUM_COL];

  logic                     w_load;
  logic                     w_adv;
  logic                     w_flush_final;
  logic [ROW_W-1:0]         w_next_row;
  logic [ROW_W-1:0]         w_row_sel;
  logic [NUM_COL*ACC_W-1:0] w_row_data;

  logic [DATA_W-1:0] w_a_h [NUM_ROW][NUM_COL];
  logic [DATA_W-1:0] w_b_v [NUM_ROW][NUM_COL];
  logic [ACC_W-1:0]  w_acc [NUM_ROW][NUM_COL];

  // The whole datapath moves on an accepted beat or on every FLUSH cycle.
  assign w_load        = (r_state == ST_LOAD);
  assign w_adv         = (w_load && i_in_valid) || (r_state == ST_FLUSH);
  assign w_flush_final = (r_state == ST_FLUSH) && (r_flush_cnt == FLUSH_LAST);

  // Row lane r is delayed r advances so A[r][k] meets B[k][c] at PE(r,c).
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_a_skew
    logic [DATA_W-1:0] w_src;
    assign w_src = w_load ? i_a_in[r*DATA_W +: DATA_W] : {DATA_W{1'b0}};
    if (r == 0) begin : g_direct
      assign w_a_h[r][0] = w_src;
    end else begin : g_dly
      logic [DATA_W-1:0] r_dly [r];
      // Row skew shift line.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int j = 0; j < r; j++) r_dly[j] <= {DATA_W{1'b0}};
        end else if (w_adv) begin
          r_dly[0] <= w_src;
          for (int j = 1; j < r; j++) r_dly[j] <= r_dly[j-1];
        end
      end
      assign w_a_h[r][0] = r_dly[r-1];
    end
  end

  // Column lane c is delayed c advances.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_b_skew
    logic [DATA_W-1:0] w_src;
    assign w_src = w_load ? i_b_in[c*DATA_W +: DATA_W] : {DATA_W{1'b0}};
    if (c == 0) begin : g_direct
      assign w_b_v[0][c] = w_src;
    end else begin : g_dly
      logic [DATA_W-1:0] r_dly [c];
      // Column skew shift line.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int j = 0; j < c; j++) r_dly[j] <= {DATA_W{1'b0}};
        end else if (w_adv) begin
          r_dly[0] <= w_src;
          for (int j = 1; j < c; j++) r_dly[j] <= r_dly[j-1];
        end
      end
      assign w_b_v[0][c] = r_dly[c-1];
    end
  end

  // PE grid: a flows right, b flows down; edge outputs are dropped.
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      logic [DATA_W-1:0] w_a_o;
      logic [DATA_W-1:0] w_b_o;
      sa_os_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_pe (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_adv       (w_adv),
        .i_clear_acc (w_flush_final),
        .i_a         (w_a_h[r][c]),
        .i_b         (w_b_v[r][c]),
        .o_a         (w_a_o),
        .o_b         (w_b_o),
        .o_acc       (w_acc[r][c])
      );
      if (c < NUM_COL - 1) begin : g_a_fwd
        assign w_a_h[r][c+1] = w_a_o;
      end else begin : g_a_end
        logic [DATA_W-1:0] w_unused_a;
        assign w_unused_a = w_a_o;
      end
      if (r < NUM_ROW - 1) begin : g_b_fwd
        assign w_b_v[r+1][c] = w_b_o;
      end else begin : g_b_end
        logic [DATA_W-1:0] w_unused_b;
        assign w_unused_b = w_b_o;
      end
    end
  end

  // Result bank captures every accumulator in the last FLUSH cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_ROW; r++)
        for (int c = 0; c < NUM_COL; c++)
          r_bank[r][c] <= {ACC_W{1'b0}};
    end else if (w_flush_final) begin
      for (int r = 0; r < NUM_ROW; r++)
        for (int c = 0; c < NUM_COL; c++)
          r_bank[r][c] <= w_acc[r][c];
    end
  end

  // Row 0 is fetched on DRAIN entry, afterwards the row after the current one.
  assign w_next_row = r_out_row + ROW_ONE;
  assign w_row_sel  = r_out_valid ? w_next_row : {ROW_W{1'b0}};

  // Pack the selected bank row into an output word.
  always_comb begin
    w_row_data = {(NUM_COL*ACC_W){1'b0}};
    for (int c = 0; c < NUM_COL; c++) begin
      w_row_data[c*ACC_W +: ACC_W] = r_bank[w_row_sel][c];
    end
  end

  // Job FSM with counters and all registered handshake/result outputs.
  // DRAIN spends its first cycle loading row 0 into the output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_k_len     <= {K_W{1'b0}};
      r_beat_cnt  <= {K_W{1'b0}};
      r_flush_cnt <= {FL_W{1'b0}};
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_out_row   <= {ROW_W{1'b0}};
      r_out_data  <= {(NUM_COL*ACC_W){1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_k_len     <= i_k_len;
            r_beat_cnt  <= {K_W{1'b0}};
            r_flush_cnt <= {FL_W{1'b0}};
            r_busy      <= 1'b1;
            if (i_k_len != {K_W{1'b0}}) begin
              r_state    <= ST_LOAD;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_LOAD: begin
          if (i_in_valid) begin
            r_beat_cnt <= r_beat_cnt + K_ONE;
            if (r_beat_cnt == (r_k_len - K_ONE)) begin
              r_state    <= ST_FLUSH;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (w_flush_final) begin
            r_state     <= ST_DRAIN;
            r_flush_cnt <= {FL_W{1'b0}};
          end else begin
            r_flush_cnt <= r_flush_cnt + {{(FL_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DRAIN: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_row   <= {ROW_W{1'b0}};
            r_out_data  <= w_row_data;
            r_out_last  <= (LAST_ROW == {ROW_W{1'b0}});
          end else if (i_out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_row   <= {ROW_W{1'b0}};
              r_out_data  <= {(NUM_COL*ACC_W){1'b0}};
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_out_row  <= w_next_row;
              r_out_data <= w_row_data;
              r_out_last <= (w_next_row == LAST_ROW);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_out_row   = r_out_row;
  assign o_out_data  = r_out_data;
  assign o_done      = r_done;

endmodule

// File: tb/tb_sa_os_engine.sv
// Bench for sa_os_engine: a signed and an unsigned 4x4 instance with 16-bit
// accumulators share all inputs; each result row is compared with a matrix
// product computed directly from the operand tables.
module tb_sa_os_engine;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int NR   = 4;
  localparam int NC   = 4;
  localparam int KW   = 4;
  localparam int KMAX = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, in_valid, out_ready;
  logic [KW-1:0]    k_len;
  logic [NR*DW-1:0] a_in;
  logic [NC*DW-1:0] b_in;

  logic             s_busy, s_in_ready, s_out_valid, s_out_last, s_done;
  logic [NC*AW-1:0] s_out_data;
  logic [1:0]       s_out_row;
  logic             u_busy, u_in_ready, u_out_valid, u_out_last, u_done;
  logic [NC*AW-1:0] u_out_data;
  logic [1:0]       u_out_row;

  sa_os_engine #(.DATA_W(DW), .ACC_W(AW), .NUM_ROW(NR), .NUM_COL(NC), .K_W(KW), .SIGNED(1'b1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_k_len(k_len), .o_busy(s_busy),
    .i_in_valid(in_valid), .o_in_ready(s_in_ready), .i_a_in(a_in), .i_b_in(b_in),
    .o_out_valid(s_out_valid), .i_out_ready(out_ready), .o_out_data(s_out_data),
    .o_out_row(s_out_row), .o_out_last(s_out_last), .o_done(s_done));

  sa_os_engine #(.DATA_W(DW), .ACC_W(AW), .NUM_ROW(NR), .NUM_COL(NC), .K_W(KW), .SIGNED(1'b0)) dut_u (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_k_len(k_len), .o_busy(u_busy),
    .i_in_valid(in_valid), .o_in_ready(u_in_ready), .i_a_in(a_in), .i_b_in(b_in),
    .o_out_valid(u_out_valid), .i_out_ready(out_ready), .o_out_data(u_out_data),
    .o_out_row(u_out_row), .o_out_last(u_out_last), .o_done(u_done));

  int tests = 0;
  int fails = 0;
  logic [7:0] am [NR][KMAX];
  logic [7:0] bm [KMAX][NC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // C row r = sum over k of A[r][k]*B[k][c], reduced modulo 2^AW.
  function automatic logic [NC*AW-1:0] exp_row(input int r, input int k, input bit sgn);
    logic [NC*AW-1:0] v;
    longint s;
    v = '0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int kk = 0; kk < k; kk++) begin
        if (sgn) s += longint'($signed(am[r][kk])) * longint'($signed(bm[kk][c]));
        else     s += longint'(am[r][kk]) * longint'(bm[kk][c]);
      end
      v[c*AW +: AW] = s[AW-1:0];
    end
    return v;
  endfunction

  function automatic logic [NR*DW-1:0] col_a(input int k);
    logic [NR*DW-1:0] v;
    for (int r = 0; r < NR; r++) v[r*DW +: DW] = am[r][k];
    return v;
  endfunction

  function automatic logic [NC*DW-1:0] row_b(input int k);
    logic [NC*DW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = bm[k][c];
    return v;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < KMAX; i++) begin
      for (int r = 0; r < NR; r++) am[r][i] = 8'($urandom);
      for (int c = 0; c < NC; c++) bm[i][c] = 8'($urandom);
    end
  endtask

  task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < KMAX; i++) begin
      for (int r = 0; r < NR; r++) am[r][i] = av;
      for (int c = 0; c < NC; c++) bm[i][c] = bv;
    end
  endtask

  // One job: start, feed k beats, wait for results, drain with optional
  // backpressure on bp_row, optional reset at abort_row, optional stray
  // start pulse at beat poke_beat.
  task automatic run_job(input int k, input bit bubbles, input int bp_row,
                         input int abort_row, input int poke_beat);
    int  beat, cyc, lat;
    bit  ph;
    k_len = KW'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    k_len = KW'($urandom);
    chk("busy_s", 64'(s_busy), 64'd1);
    chk("busy_u", 64'(u_busy), 64'd1);
    beat = 0; cyc = 0; ph = 1'b0;
    while (beat < k && cyc < 200) begin
      in_valid = bubbles ? ph : 1'b1;
      ph = ~ph;
      if (in_valid) begin
        a_in = col_a(beat);
        b_in = row_b(beat);
      end else begin
        a_in = NR*DW'($urandom);
        b_in = NC*DW'($urandom);
      end
      start = (beat == poke_beat);
      chk("in_ready_load", 64'(s_in_ready), 64'd1);
      tick();
      if (in_valid) beat++;
      cyc++;
    end
    chk("beats_accepted", 64'(beat), 64'(k));
    start    = 1'b0;
    in_valid = 1'($urandom);
    a_in     = NR*DW'($urandom);
    b_in     = NC*DW'($urandom);
    chk("in_ready_after_load", 64'(s_in_ready), 64'd0);
    lat = 0;
    while (!s_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk("first_valid_latency", 64'(lat), 64'(NR + NC));
    for (int r = 0; r < NR; r++) begin
      out_ready = 1'b1;
      if (r == abort_row) begin
        chk("abort_row_idx", 64'(s_out_row), 64'(r));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 64'(s_out_valid), 64'd0);
        chk("abort_busy", 64'(s_busy), 64'd0);
        chk("abort_done", 64'(s_done), 64'd0);
        chk("abort_row", 64'(s_out_row), 64'd0);
        chk("abort_data", s_out_data, 64'd0);
        tick();
        chk("abort_no_done", 64'(s_done | u_done), 64'd0);
        chk("abort_idle_busy", 64'(u_busy), 64'd0);
        return;
      end
      if (r == bp_row) begin
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("bp_valid", 64'(s_out_valid), 64'd1);
          chk("bp_row", 64'(s_out_row), 64'(r));
          chk("bp_data", s_out_data, exp_row(r, k, 1'b1));
        end
        out_ready = 1'b1;
      end
      chk("row_valid", 64'(s_out_valid & u_out_valid), 64'd1);
      chk("row_idx", 64'(s_out_row), 64'(r));
      chk("row_idx_u", 64'(u_out_row), 64'(r));
      chk("row_data_s", s_out_data, exp_row(r, k, 1'b1));
      chk("row_data_u", u_out_data, exp_row(r, k, 1'b0));
      chk("row_last", 64'(s_out_last), 64'(r == NR - 1));
      chk("row_no_done", 64'(s_done), 64'd0);
      tick();
    end
    chk("done_s", 64'(s_done), 64'd1);
    chk("done_u", 64'(u_done), 64'd1);
    chk("idle_busy", 64'(s_busy), 64'd0);
    chk("idle_valid", 64'(s_out_valid), 64'd0);
    tick();
    chk("done_pulse", 64'(s_done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    k_len = '0; a_in = '0; b_in = '0;
    tick();
    tick();
    chk("rst_busy", 64'(s_busy | u_busy), 64'd0);
    chk("rst_in_ready", 64'(s_in_ready | u_in_ready), 64'd0);
    chk("rst_out_valid", 64'(s_out_valid | u_out_valid), 64'd0);
    chk("rst_out_last", 64'(s_out_last), 64'd0);
    chk("rst_done", 64'(s_done), 64'd0);
    chk("rst_out_row", 64'(s_out_row), 64'd0);
    chk("rst_out_data", s_out_data, 64'd0);
    rst = 1'b0;
    tick();

    // Identity A with B[k][c] = 4k+c+1.
    for (int i = 0; i < KMAX; i++) begin
      for (int r = 0; r < NR; r++) am[r][i] = (r == i) ? 8'd1 : 8'd0;
      for (int c = 0; c < NC; c++) bm[i][c] = 8'(i * 4 + c + 1);
    end
    run_job(4, 1'b0, -1, -1, -1);

    // Accumulator wrap, signed and unsigned corners.
    fill_const(8'h80, 8'h80);
    run_job(3, 1'b0, -1, -1, -1);
    fill_const(8'hFF, 8'hFF);
    run_job(3, 1'b0, -1, -1, -1);

    // Bubbles versus gap-free feed of the same operands.
    fill_rand();
    run_job(5, 1'b1, -1, -1, -1);
    run_job(5, 1'b0, -1, -1, -1);

    // Backpressure on row 1.
    fill_rand();
    run_job(4, 1'b0, 1, -1, -1);

    // Empty job, then a stray start in the middle of LOAD.
    run_job(0, 1'b0, -1, -1, -1);
    fill_rand();
    run_job(6, 1'b0, -1, -1, 2);

    // Reset during DRAIN, then a fresh K=1 job.
    fill_rand();
    run_job(3, 1'b0, -1, 2, -1);
    fill_const(8'd1, 8'd2);
    run_job(1, 1'b0, -1, -1, -1);

    // Random jobs.
    for (int n = 0; n < 4; n++) begin
      fill_rand();
      run_job(int'($urandom_range(1, 12)), 1'($urandom), int'($urandom_range(0, 4)) - 1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sa_os_engine.md
Name: sa_os_engine

Overview:
- Parametrised output-stationary systolic matrix-multiply engine; successor to the fixed 8-bit PE grid.
- Computes C[NUM_ROW x NUM_COL] = A[NUM_ROW x K] * B[K x NUM_COL] with full-width accumulators.
- Adds internal input skewing, a start/done job FSM, valid/ready streaming input and a row-serial drain with backpressure.
- Sits between the on-chip operand buffers and the result write-back path of the accelerator.

Parameters:
- DATA_W, 8, operand width in bits.
- ACC_W, 24, accumulator and result width; must be at least 2*DATA_W.
- NUM_ROW, 16, PE rows, which is also the A-vector lanes.
- NUM_COL, 16, PE columns, which is also the B-vector lanes.
- K_W, 10, width of k_len; K_MAX = 2^K_W - 1.
- SIGNED, 1, 1 means operands and products are two's complement; 0 means unsigned.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  job start pulse; honoured only in IDLE.
- k_len  in  K_W  inner dimension K; sampled when start is accepted.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- a_in  in  NUM_ROW*DATA_W  column k of A; lane r-1 feeds PE row r.
- b_in  in  NUM_COL*DATA_W  row k of B; lane c-1 feeds PE column c.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the row.
- out_data  out  NUM_COL*ACC_W  result row; lane c-1 holds C[r][c].
- out_row  out  $clog2(NUM_ROW)  index of the row presented (0-based).
- out_last  out  1  high together with the final row.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (clk edge with rst=1):
  - FSM goes to IDLE.
  - All accumulators, skew registers, PE pass registers and the result bank are cleared.
  - Outputs: in_ready=0, out_valid=0, out_last=0, done=0, busy=0, out_row=0, out_data=0.
  - Reset mid-job aborts the job. No done pulse is produced.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
  - IDLE -> LOAD on start with k_len>0.
  - IDLE -> FLUSH on start with k_len==0. The result is all zeros.
- LOAD:
  - A beat is accepted when in_valid && in_ready.
  - The array and skew lines advance only on an accepted beat. With no beat the whole datapath holds, so bubbles are harmless.
  - A beat counter counts up to k_len. The accepted beat k_len moves the FSM to FLUSH in the next cycle.
- Skew:
  - Row lane r is delayed r-1 advances; column lane c is delayed c-1 advances.
  - Each PE forwards a to the right and b downward through one register per advance.
  - A PE accumulates acc += a*b on every advance.
- FLUSH:
  - Runs for exactly NUM_ROW+NUM_COL-1 cycles; the datapath advances every cycle.
  - Zeros are injected at all lanes, so extra products add 0.
  - In the final FLUSH cycle all accumulators are copied to the result bank and cleared. The FSM then enters DRAIN with out_row=0.
- DRAIN:
  - out_valid=1 and out_data = bank[out_row].
  - out_row increments on each out_valid && out_ready.
  - out_data and out_row stay stable while out_ready=0.
  - out_last = (out_row == NUM_ROW-1).
  - Acceptance of the last row drives done=1 in the next cycle and returns the FSM to IDLE.
- Arithmetic:
  - Each product is extended to ACC_W, sign-extended when SIGNED=1 and zero-extended otherwise.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- Latency: the first out_valid rises at cycle (last beat accept) + NUM_ROW + NUM_COL + 1.
- start is ignored while busy=1. in_valid is ignored outside LOAD.

Decomposition:
- Package sa_pkg holds the state enum (IDLE, LOAD, FLUSH, DRAIN) and a helper function for product extension per SIGNED.
- Sub-module sa_os_pe holds one PE:
  - Inputs: adv, clear_acc, a_in, b_in.
  - Outputs: a_out, b_out, acc.
  - It is instantiated NUM_ROW*NUM_COL times in a generate loop.
- Skew lines, FSM, counters and the result bank stay in the top module.

Test Plan:
- Identity: NUM_ROW=NUM_COL=4, K=4, A=I, B[k][c]=k*4+c+1, out_ready=1 -> rows 0..3 are {1,2,3,4},{5,6,7,8},... ; out_last on row 3; done one cycle later.
- Signed wrap: SIGNED=1, ACC_W=16, K=3, all a=-128 and b=-128 -> every C = 49152 mod 2^16 read as signed = -16384. Repeat with SIGNED=0 and a=b=255 -> 195075 mod 65536 = 64003.
- Bubbles: K=5 with in_valid deasserted on alternating cycles -> results identical to the gap-free run; in_ready stays 1 throughout LOAD.
- Backpressure: out_ready low for 3 cycles on row 1 -> out_data and out_row hold; each row appears exactly once; done fires once.
- k_len=0 and start while busy -> k_len=0 drains all-zero rows; a second start pulse during LOAD is ignored and the beat count is unchanged.
- Reset mid-DRAIN: assert rst at row 2 -> next cycle out_valid=0, busy=0, no done. A new K=1 job with a=1 and b=2 yields all outputs 2, proving the accumulators were cleared.
